id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
// - ID/EX pipeline stage directly downstream of the register file.
// - Captures the register file read data, decoded fields and control into the ID/EX register.
// - Applies a WB->ID bypass for same-cycle writes, detects load-use hazards and inserts one bubble.
// - Honours EX backpressure and branch flush, and keeps a saturating stall counter.
// PARAMETERS
// - DATA_W    32   datapath width
// - REG_AW    5    register index width
// - CTRL_W    10   control bundle width: {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,RegDst,ALUOp[3:0]}
// - CNT_W     16   stall counter width
// PORTS
// - CLK            in   1       clock; all state updates on posedge
// - RST_N          in   1       reset, synchronous, active-low
// - id_valid       in   1       ID holds a real instruction
// - id_rs          in   REG_AW  instr[25:21]
// - id_rt          in   REG_AW  instr[20:16]
// - id_rd          in   REG_AW  instr[15:11]
// - id_rs_data     in   DATA_W  register file readData1
// - id_rt_data     in   DATA_W  register file readData2
// - id_imm         in   16      instr[15:0]
// - id_ctrl        in   CTRL_W  decoded control bundle
// - wb_reg_write   in   1       WB write enable (same signal that drives register file RegWrite)
// - wb_write_reg   in   REG_AW  WB destination
// - wb_write_data  in   DATA_W  WB data
// - flush          in   1       branch/jump resolved taken in EX; kill ID instruction
// - ex_ready       in   1       EX can accept a new instruction this cycle
// - stall_if_id    out  1       combinational; hold PC and IF/ID register
// - ex_valid       out  1       ID/EX register holds a real instruction
// - ex_rs, ex_rt   out  REG_AW  source indices, used by the EX forwarding unit
// - ex_dest        out  REG_AW  destination: RegDst ? rd : rt; forced to 0 when RegWrite=0
// - ex_a, ex_b     out  DATA_W  operand values after WB bypass
// - ex_imm         out  DATA_W  sign-extended id_imm
// - ex_ctrl        out  CTRL_W  control bundle; all zeros when ex_valid=0
// - stall_cnt      out  CNT_W   count of bubble cycles; saturates at all-ones
// BEHAVIOUR
// - Reset (RST_N=0 at posedge): every output register is set to 0, FSM goes to RUN, stall_cnt=0. Reset overrides all other inputs.
// - Bypass: a = (wb_reg_write && wb_write_reg==id_rs && id_rs!=0) ? wb_write_data : id_rs_data. b uses the same rule with rt.
// - Reads of $0 always yield 0 regardless of bypass.
// - Load-use hazard:
//   - lu = id_valid & ex_valid & ex_ctrl.MemRead & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt).
//   - The rt match counts even when ALUSrc=1, which is conservative.
// - FSM states: RUN, BUBBLE, HOLD. Priority order: reset > flush > hold > load-use.
//   - RUN, flush=1: ID/EX is loaded with a bubble (ex_valid=0, ex_ctrl=0); next state RUN; stall_if_id=0.
//   - RUN, ex_ready=0: the ID/EX register holds; stall_if_id=1; next state HOLD.
//   - RUN, lu=1: a bubble is loaded; stall_if_id=1; stall_cnt+1; next state BUBBLE.
//   - RUN, otherwise: ID/EX loads the ID values with ex_valid=id_valid; stall_if_id=0.
//   - BUBBLE: lu is re-evaluated against the bubble (ex_valid=0), so it is always clear; the held instruction loads; next state RUN. A load-use hazard therefore costs exactly one cycle.
//   - HOLD: stays in HOLD while ex_ready=0 with the register frozen. When ex_ready=1, the normal RUN decision is applied in the same cycle.
// - Flush during HOLD: the bubble is loaded immediately and the state goes to RUN.
// - Latency: 1 cycle from ID inputs to ex_* outputs.
// - A WB write to the register being read is visible in the same cycle through the bypass.
// - Width: ex_imm = {{16{id_imm[15]}}, id_imm}. stall_cnt does not wrap.
// STRUCTURE
// - Shared package mips_pkg holds:
//   - CTRL_W, the bit indices CTRL_REGWRITE..CTRL_ALUOP, and REG_ZERO=5'd0.
//   - A typedef for the ID/EX bundle and the state enum {RUN,BUBBLE,HOLD}.
// - Sub-module id_ex_hazard: purely combinational; computes lu and the bypass selects.
// - This top module holds the FSM, the ID/EX register and the counter.
// TESTING
// - Reset mid-stream: RST_N=0 for 1 cycle during HOLD -> next cycle ex_valid=0, ex_ctrl=0, stall_cnt=0, stall_if_id=0.
// - Bypass: wb writes $5=0xDEADBEEF while id_rs=5, id_rs_data=0x0 -> ex_a=0xDEADBEEF next cycle. Repeat with id_rs=0 -> ex_a=0.
// - Load-use: lw $8 in EX, then add $9,$8,$1 in ID -> stall_if_id=1 for 1 cycle, one bubble, add issues on cycle +2, stall_cnt=1.
// - Backpressure: ex_ready=0 for 3 cycles -> ex_* are stable and stall_if_id=1 for 3 cycles; the instruction advances on the first cycle with ex_ready=1.
// - Flush beats load-use: flush=1 and lu=1 in the same cycle -> bubble loaded, stall_if_id=0, stall_cnt unchanged.
// - Saturation: CNT_W=4 with 20 forced load-use bubbles -> stall_cnt stays at 4'hF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the ID/EX stage: control-bundle bit layout,
// the ID/EX register bundle and the stage FSM encoding.
package mips_pkg;

    localparam int CTRL_W        = 10;
    localparam int CTRL_REGWRITE = 9;
    localparam int CTRL_MEMREAD  = 8;
    localparam int CTRL_MEMWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_REGDST   = 4;
    localparam int CTRL_ALUOP    = 0;
    localparam int CTRL_ALUOP_W  = 4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dest;
        logic [31:0]       a;
        logic [31:0]       b;
        logic [31:0]       imm;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_t;

endpackage

// File: rtl/id_ex_hazard.sv
// Combinational load-use detection and WB->ID bypass selection for the
// instruction currently sitting in ID.
module id_ex_hazard
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_reg,
    output logic              lu,
    output logic              a_wb,
    output logic              b_wb,
    output logic              a_zero,
    output logic              b_zero
);

    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(REG_ZERO);

    logic dest_match;

    always_comb begin
        a_zero     = (id_rs == ZERO_IDX);
        b_zero     = (id_rt == ZERO_IDX);
        a_wb       = wb_reg_write && (wb_write_reg == id_rs) && !a_zero;
        b_wb       = wb_reg_write && (wb_write_reg == id_rt) && !b_zero;
        // rt is matched even for immediate-form instructions; a rare spurious stall is cheaper than decoding ALUSrc here
        dest_match = (ex_dest == id_rs) || (ex_dest == id_rt);
        lu         = id_valid && ex_valid && ex_mem_read && (ex_dest != ZERO_IDX) && dest_match;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, one-cycle load-use bubble,
// EX backpressure hold, branch flush and a saturating bubble counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              stall_if_id,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_dest,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    import mips_pkg::*;

    state_e state, state_nxt;

    logic lu, lu_eff;
    logic a_wb, b_wb, a_zero, b_zero;
    logic do_load, do_bubble, cnt_inc;

    logic [DATA_W-1:0] a_nxt, b_nxt, imm_nxt;
    logic [CTRL_W-1:0] ctrl_nxt;
    logic [REG_AW-1:0] dest_nxt;

    id_ex_hazard #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_ctrl[CTRL_MEMREAD]),
        .ex_dest      (ex_dest),
        .wb_reg_write (wb_reg_write),
        .wb_write_reg (wb_write_reg),
        .lu           (lu),
        .a_wb         (a_wb),
        .b_wb         (b_wb),
        .a_zero       (a_zero),
        .b_zero       (b_zero)
    );

    // In BUBBLE the register already holds the inserted bubble, so the held instruction never re-stalls
    assign lu_eff = lu && (state != BUBBLE);

    always_comb begin
        a_nxt    = a_zero ? '0 : (a_wb ? wb_write_data : id_rs_data);
        b_nxt    = b_zero ? '0 : (b_wb ? wb_write_data : id_rt_data);
        imm_nxt  = {{(DATA_W-16){id_imm[15]}}, id_imm};
        ctrl_nxt = id_valid ? id_ctrl : '0;
        dest_nxt = '0;
        if (ctrl_nxt[CTRL_REGWRITE]) begin
            dest_nxt = ctrl_nxt[CTRL_REGDST] ? id_rd : id_rt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Every state resolves flush > hold > load-use the same way; HOLD and BUBBLE only differ in how they were entered
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = RUN;
        end else if (!ex_ready) begin
            state_nxt = HOLD;
        end else if (lu_eff) begin
            state_nxt = BUBBLE;
        end else begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        do_load     = 1'b0;
        do_bubble   = 1'b0;
        cnt_inc     = 1'b0;
        stall_if_id = 1'b0;
        if (!RST_N) begin
            stall_if_id = 1'b0;
        end else if (flush) begin
            do_bubble = 1'b1;
        end else if (!ex_ready) begin
            stall_if_id = 1'b1;
        end else if (lu_eff) begin
            do_bubble   = 1'b1;
            stall_if_id = 1'b1;
            cnt_inc     = 1'b1;
        end else begin
            do_load = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_dest  <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
        end else if (do_bubble) begin
            ex_valid <= 1'b0;
            ex_dest  <= '0;
            ex_ctrl  <= '0;
        end else if (do_load) begin
            ex_valid <= id_valid;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_dest  <= dest_nxt;
            ex_a     <= a_nxt;
            ex_b     <= b_nxt;
            ex_imm   <= imm_nxt;
            ex_ctrl  <= ctrl_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_cnt <= '0;
        end else if (cnt_inc && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
